// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line responder.
// Receives 48-bit host command frames, checks framing (and optionally CRC7),
// presents index/argument to card logic, then sends the 48-bit card response
// with CRC7 after an NCR gap.
// Optional feature macro: CMD_CRC_CHECK_EN (enables the received CRC7 check
// and crc_err; response CRC7 generation is always present).
module sd_card_cmd_responder #(
    parameter int unsigned NCR_CYCLES  = 2,
    parameter int unsigned RSP_TIMEOUT = 64
) (
    input  logic        i_sd_clk,
    input  logic        i_rst_l,
    input  logic        i_cmd_in,
    output logic        o_cmd_out,
    output logic        o_cmd_oe,
    output logic        o_cmd_valid,
    output logic [5:0]  o_cmd_index,
    output logic [31:0] o_cmd_arg,
    output logic        o_rsp_ready,
    input  logic        i_rsp_valid,
    input  logic        i_rsp_none,
    input  logic [5:0]  i_rsp_index,
    input  logic [31:0] i_rsp_arg,
    output logic        o_busy,
    output logic        o_crc_err,
    output logic        o_frame_err
);

    typedef enum logic [2:0] {
        StIdle,
        StRx,
        StCheck,
        StWaitRsp,
        StNcr,
        StTx
    } state_t;

    localparam logic [6:0]  NcrLast  = 7'(NCR_CYCLES);
    localparam logic [31:0] WaitLast = 32'(RSP_TIMEOUT - 32'd1);

    // One serial step of CRC7, x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    function automatic logic [6:0] crc7_of40(input logic [39:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

    state_t      r_state;
    logic [47:0] r_rx_sr;
    logic [47:0] r_tx_sr;
    logic [5:0]  r_bit_cnt;
    logic [6:0]  r_ncr_cnt;
    logic [31:0] r_wait_cnt;
    logic        r_cmd_out;
    logic        r_cmd_oe;
    logic        r_cmd_valid;
    logic [5:0]  r_cmd_index;
    logic [31:0] r_cmd_arg;
    logic        r_rsp_ready;
    logic        r_busy;
    logic        r_frame_err;
`ifdef CMD_CRC_CHECK_EN
    logic [6:0]  r_crc;
    logic        r_crc_err;
`else
    logic        w_unused_crc;
`endif

    logic [39:0] w_rsp_payload;
    logic [47:0] w_rsp_frame;

    // Response frame assembled from the card-logic fields at handshake time.
    always_comb begin
        w_rsp_payload = {2'b00, i_rsp_index, i_rsp_arg};
        w_rsp_frame   = {w_rsp_payload, crc7_of40(w_rsp_payload), 1'b1};
    end

    // Main FSM: receive, check, wait for card logic, NCR gap, transmit.
    always_ff @(posedge i_sd_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_state     <= StIdle;
            r_rx_sr     <= 48'd0;
            r_tx_sr     <= 48'd0;
            r_bit_cnt   <= 6'd0;
            r_ncr_cnt   <= 7'd0;
            r_wait_cnt  <= 32'd0;
            r_cmd_out   <= 1'b1;
            r_cmd_oe    <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_index <= 6'd0;
            r_cmd_arg   <= 32'd0;
            r_rsp_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef CMD_CRC_CHECK_EN
            r_crc       <= 7'd0;
            r_crc_err   <= 1'b0;
`endif
        end else begin
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef CMD_CRC_CHECK_EN
            r_crc_err   <= 1'b0;
`endif
            unique case (r_state)
                StIdle: begin
                    if (!i_cmd_in) begin
                        // Start bit captured; a zero bit leaves the CRC at its zero init.
                        r_state   <= StRx;
                        r_bit_cnt <= 6'd1;
                        r_rx_sr   <= 48'd0;
                        r_busy    <= 1'b1;
`ifdef CMD_CRC_CHECK_EN
                        r_crc     <= 7'd0;
`endif
                    end
                end
                StRx: begin
                    r_rx_sr <= {r_rx_sr[46:0], i_cmd_in};
`ifdef CMD_CRC_CHECK_EN
                    if (r_bit_cnt < 6'd40) begin
                        r_crc <= crc7_step(r_crc, i_cmd_in);
                    end
`endif
                    if (r_bit_cnt == 6'd47) begin
                        r_state <= StCheck;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                end
                StCheck: begin
                    if (!r_rx_sr[46] || !r_rx_sr[0]) begin
                        r_frame_err <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end
`ifdef CMD_CRC_CHECK_EN
                    else if (r_rx_sr[7:1] != r_crc) begin
                        r_crc_err <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= StIdle;
                    end
`endif
                    else begin
                        r_cmd_index <= r_rx_sr[45:40];
                        r_cmd_arg   <= r_rx_sr[39:8];
                        r_cmd_valid <= 1'b1;
                        r_rsp_ready <= 1'b1;
                        r_wait_cnt  <= 32'd0;
                        r_state     <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    if (i_rsp_none) begin
                        r_rsp_ready <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end else if (i_rsp_valid) begin
                        r_tx_sr     <= w_rsp_frame;
                        r_ncr_cnt   <= 7'd0;
                        r_rsp_ready <= 1'b0;
                        r_state     <= StNcr;
                    end else if ((RSP_TIMEOUT != 0) && (r_wait_cnt == WaitLast)) begin
                        r_rsp_ready <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end else if (RSP_TIMEOUT != 0) begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                StNcr: begin
                    // Handshake cycle plus NCR_CYCLES released cycles before the start bit.
                    if (r_ncr_cnt == NcrLast) begin
                        r_cmd_oe  <= 1'b1;
                        r_cmd_out <= r_tx_sr[47];
                        r_tx_sr   <= {r_tx_sr[46:0], 1'b1};
                        r_bit_cnt <= 6'd0;
                        r_state   <= StTx;
                    end else begin
                        r_ncr_cnt <= r_ncr_cnt + 7'd1;
                    end
                end
                StTx: begin
                    if (r_bit_cnt == 6'd47) begin
                        r_cmd_oe  <= 1'b0;
                        r_cmd_out <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= StIdle;
                    end else begin
                        r_cmd_out <= r_tx_sr[47];
                        r_tx_sr   <= {r_tx_sr[46:0], 1'b1};
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

`ifdef CMD_CRC_CHECK_EN
    assign o_crc_err = r_crc_err;
`else
    // Received CRC field is deliberately ignored in this build.
    assign w_unused_crc = ^r_rx_sr[7:1];
    assign o_crc_err    = 1'b0;
`endif

    assign o_cmd_out   = r_cmd_out;
    assign o_cmd_oe    = r_cmd_oe;
    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd_index = r_cmd_index;
    assign o_cmd_arg   = r_cmd_arg;
    assign o_rsp_ready = r_rsp_ready;
    assign o_busy      = r_busy;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench for sd_card_cmd_responder: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sd_card_cmd_responder;

    localparam int unsigned NCR = 2;
    localparam int unsigned TMO = 64;

    localparam int KValid = 0;
    localparam int KCrc   = 1;
    localparam int KFrame = 2;
    localparam int KRsp   = 3;

    localparam int ExpAccept = 0;
    localparam int ExpCrc    = 1;
    localparam int ExpFrame  = 2;

    localparam int MValid   = 0;
    localparam int MNone    = 1;
    localparam int MBoth    = 2;
    localparam int MTimeout = 3;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        cmd_in = 1'b1;
    logic        rsp_valid = 1'b0;
    logic        rsp_none = 1'b0;
    logic [5:0]  rsp_index = 6'd0;
    logic [31:0] rsp_arg = 32'd0;
    logic        cmd_out, cmd_oe, cmd_valid, rsp_ready, busy, crc_err, frame_err;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    sd_card_cmd_responder #(
        .NCR_CYCLES (NCR),
        .RSP_TIMEOUT(TMO)
    ) dut (
        .i_sd_clk   (clk),
        .i_rst_l    (rst_l),
        .i_cmd_in   (cmd_in),
        .o_cmd_out  (cmd_out),
        .o_cmd_oe   (cmd_oe),
        .o_cmd_valid(cmd_valid),
        .o_cmd_index(cmd_index),
        .o_cmd_arg  (cmd_arg),
        .o_rsp_ready(rsp_ready),
        .i_rsp_valid(rsp_valid),
        .i_rsp_none (rsp_none),
        .i_rsp_index(rsp_index),
        .i_rsp_arg  (rsp_arg),
        .o_busy     (busy),
        .o_crc_err  (crc_err),
        .o_frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] frame;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_bad = 0;

    // Reference CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] ref_crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] rsp_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b00, idx, arg, ref_crc7({2'b00, idx, arg}), 1'b1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int kind, input logic [5:0] idx, input logic [31:0] arg,
                            input logic [47:0] frame);
        exp_t e;
        e.kind  = kind;
        e.idx   = idx;
        e.arg   = arg;
        e.frame = frame;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, output exp_t e, output bit ok);
        n_checks++;
        ok = 1'b0;
        e.kind = -1; e.idx = '0; e.arg = '0; e.frame = '0;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: DUT produced kind %0d, expected none at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                n_bad++;
                $display("FAIL event: DUT produced kind %0d, expected kind %0d at %0t",
                         kind, e.kind, $time);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Monitor: consumes expected events as the DUT presents outputs.
    logic [47:0] mon_bits = 48'd0;
    int          mon_n = 0;
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!rst_l) begin
            mon_n = 0;
        end else begin
            if (cmd_valid) begin
                take(KValid, e, ok);
                if (ok) begin
                    chk("cmd_index", cmd_index, e.idx);
                    chk("cmd_arg", cmd_arg, e.arg);
                end
            end
            if (crc_err) take(KCrc, e, ok);
            if (frame_err) take(KFrame, e, ok);
            if (cmd_oe) begin
                mon_bits = {mon_bits[46:0], cmd_out};
                mon_n++;
            end else if (mon_n != 0) begin
                take(KRsp, e, ok);
                if (ok) begin
                    chk("rsp_frame", mon_bits, e.frame);
                    chk("rsp_len", mon_n, 48);
                end
                chk("cmd_out_released", cmd_out, 1'b1);
                mon_n = 0;
            end
        end
    end

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            cmd_in = f[i];
            @(posedge clk); #1;
        end
        cmd_in = 1'b1;
    endtask

    // Called one cycle after the end bit was sampled, with the command accepted.
    task automatic do_response(input int mode, input logic [5:0] ri, input logic [31:0] ra,
                               input logic [47:0] exp_rsp, input int delay);
        int k;
        bit oe_seen;
        if (mode == MTimeout) begin
            k = 0;
            oe_seen = 1'b0;
            while (rsp_ready && k < 200) begin
                k++;
                if (cmd_oe) oe_seen = 1'b1;
                @(posedge clk); #1;
            end
            chk("timeout_len", k, TMO);
            chk("timeout_busy", busy, 1'b0);
            chk("timeout_oe", oe_seen, 1'b0);
            return;
        end
        chk("rsp_ready", rsp_ready, 1'b1);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        if (mode != MValid) begin
            rsp_none  = 1'b1;
            rsp_valid = (mode == MBoth);
            rsp_index = ri;
            rsp_arg   = ra;
            @(posedge clk); #1;
            rsp_none  = 1'b0;
            rsp_valid = 1'b0;
            chk("none_idle", {busy, rsp_ready, cmd_oe}, 3'b000);
            repeat (3) begin
                @(posedge clk); #1;
            end
            return;
        end
        push_exp(KRsp, '0, '0, exp_rsp);
        rsp_valid = 1'b1;
        rsp_index = ri;
        rsp_arg   = ra;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        rsp_index = 6'($urandom);
        rsp_arg   = $urandom;
        k = 0;
        while (!cmd_oe && k < 100) begin
            cmd_in = 1'($urandom);
            @(posedge clk); #1;
            k++;
        end
        chk("ncr_gap", k, NCR + 1);
        k = 0;
        while (busy && k < 100) begin
            cmd_in = 1'($urandom);
            @(posedge clk); #1;
            k++;
        end
        cmd_in = 1'b1;
        chk("tx_len", k, 48);
        chk("tx_end_lines", {cmd_oe, cmd_out}, 2'b01);
    endtask

    task automatic run_cmd(input logic [47:0] f, input int expect_kind, input int mode,
                           input logic [5:0] ri, input logic [31:0] ra,
                           input logic [47:0] exp_rsp, input int delay);
        logic [2:0] pat;
        if (expect_kind == ExpAccept) begin
            push_exp(KValid, f[45:40], f[39:8], '0);
            pat = 3'b100;
        end else if (expect_kind == ExpCrc) begin
            push_exp(KCrc, '0, '0, '0);
            pat = 3'b010;
        end else begin
            push_exp(KFrame, '0, '0, '0);
            pat = 3'b001;
        end
        send_frame(f);
        chk("pulse_early", {cmd_valid, crc_err, frame_err}, 3'b000);
        @(posedge clk); #1;
        chk("pulse", {cmd_valid, crc_err, frame_err}, pat);
        if (expect_kind == ExpAccept) begin
            do_response(mode, ri, ra, exp_rsp, delay);
        end else begin
            chk("err_idle", {busy, rsp_ready}, 2'b00);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not end, bad=%0d", n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] f;
        logic [5:0]  ci, ri;
        logic [31:0] ca, ra;
        int          ek, mode, sel, k;

        rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lines", {cmd_oe, cmd_out}, 2'b01);
        chk("rst_flags", {cmd_valid, rsp_ready, busy, crc_err, frame_err}, 5'd0);
        chk("rst_index", cmd_index, 6'd0);
        chk("rst_arg", cmd_arg, 32'd0);
        rst_l = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 1'b0);

        // CMD0, no response.
        run_cmd(48'h400000000095, ExpAccept, MNone, 6'd0, 32'd0, '0, 1);
        // CMD8 with R7 echo.
        run_cmd(48'h48000001AA87, ExpAccept, MValid, 6'd8, 32'h000001AA, 48'h08000001AA13, 0);
        // CMD17 with corrupted CRC field (0x2B).
`ifdef CMD_CRC_CHECK_EN
        run_cmd(48'h510000000057, ExpCrc, MNone, 6'd0, 32'd0, '0, 0);
`else
        run_cmd(48'h510000000057, ExpAccept, MNone, 6'd0, 32'd0, '0, 0);
`endif
        // CMD55 with end bit 0.
        run_cmd(48'h770000000064, ExpFrame, MNone, 6'd0, 32'd0, '0, 0);
        // CMD8 never answered.
        run_cmd(48'h48000001AA87, ExpAccept, MTimeout, 6'd0, 32'd0, '0, 0);

        // Reset during response bit 20.
        push_exp(KValid, 6'd8, 32'h000001AA, '0);
        send_frame(48'h48000001AA87);
        @(posedge clk); #1;
        chk("rst_cmd_valid", cmd_valid, 1'b1);
        rsp_valid = 1'b1;
        rsp_index = 6'd8;
        rsp_arg   = 32'h000001AA;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        k = 0;
        while (!cmd_oe && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_oe_up", cmd_oe, 1'b1);
        repeat (20) @(posedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        chk("midtx_lines", {cmd_oe, cmd_out}, 2'b01);
        chk("midtx_busy", busy, 1'b0);
        chk("midtx_index", cmd_index, 6'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_l = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        run_cmd(48'h400000000095, ExpAccept, MNone, 6'd0, 32'd0, '0, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            ci = 6'($urandom);
            ca = $urandom;
            f  = cmd_frame(ci, ca);
            ek = ExpAccept;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
`ifdef CMD_CRC_CHECK_EN
                ek = ExpCrc;
`endif
            end else if (sel == 1) begin
                f[46] = 1'b0;
                ek = ExpFrame;
            end else if (sel == 2) begin
                f[0] = 1'b0;
                ek = ExpFrame;
            end
            sel = int'($urandom_range(0, 5));
            mode = (sel <= 2) ? MValid : (sel == 3) ? MNone : (sel == 4) ? MBoth : MTimeout;
            ri = 6'($urandom);
            ra = $urandom;
            run_cmd(f, ek, mode, ri, ra, rsp_frame(ri, ra), int'($urandom_range(0, 20)));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_card_cmd_responder.md
Name: sd_card_cmd_responder

Overview:
- Card-side end of the SD CMD line; the counterpart of the sd_host command path.
- Deserializes 48-bit host command frames, checks framing and CRC7, and hands the index and argument to card logic.
- Then serializes the 48-bit card response, including CRC7, back onto CMD.
- Used as the device model/responder in sd_host system benches and as the front end of a card-side core.

Parameters:
NCR_CYCLES, 2, SD_clk cycles CMD stays released between response acceptance and the response start bit (legal range 2..64).
RSP_TIMEOUT, 64, cycles WAIT_RSP waits for card logic before abandoning the command (0 = wait forever).

Ports:
SD_clk  input  1  sole clock; CMD sampled and driven on rising edge.
RST_L  input  1  asynchronous active-low reset.
cmd_in  input  1  CMD line as driven by host.
cmd_out  output  1  CMD value driven by card.
cmd_oe  output  1  1 = card drives CMD.
cmd_valid  output  1  one-cycle pulse, decoded command available.
cmd_index  output  6  command index, held until next cmd_valid.
cmd_arg  output  32  command argument, held until next cmd_valid.
rsp_ready  output  1  high only in WAIT_RSP.
rsp_valid  input  1  card logic offers a response.
rsp_none  input  1  command takes no response.
rsp_index  input  6  response index field.
rsp_arg  input  32  response payload (card status / R7 echo).
busy  output  1  high in every state except IDLE.
crc_err  output  1  one-cycle pulse, CRC7 mismatch.
frame_err  output  1  one-cycle pulse, bad transmission or end bit.

Behaviour:
- Reset (async, RST_L=0):
  - state=IDLE, cmd_out=1, cmd_oe=0, cmd_valid=0, rsp_ready=0, busy=0, crc_err=0, frame_err=0, cmd_index=0, cmd_arg=0.
  - An in-flight RX or TX is aborted and CMD is released immediately.
- Command frame, MSB first: start(0), transmission(1), index[5:0], arg[31:0], crc7[6:0], end(1).
- CRC7: polynomial x^7+x^3+1, init 0, computed over the first 40 bits; computed serially as bits arrive.
- IDLE:
  - cmd_in sampled 0 -> RX with bit count=1.
  - cmd_in=1 -> stay in IDLE.
- RX:
  - Shift one bit per cycle.
  - When bit 48 (the end bit) is captured -> CHECK.
- CHECK (1 cycle):
  - Transmission bit !=1 or end bit !=1 -> frame_err pulse, then IDLE. frame_err takes precedence; crc_err is not also pulsed.
  - Else CRC mismatch -> crc_err pulse, then IDLE.
  - Else latch cmd_index/cmd_arg, cmd_valid=1 for one cycle, then WAIT_RSP.
- WAIT_RSP:
  - rsp_ready=1.
  - rsp_none=1 -> IDLE. rsp_none has priority over rsp_valid in the same cycle.
  - rsp_valid=1 -> latch rsp_index/rsp_arg, then NCR.
  - Timeout after RSP_TIMEOUT cycles -> IDLE silently.
  - cmd_in is ignored in this state.
- NCR:
  - cmd_oe=0 for exactly NCR_CYCLES cycles, then TX.
- TX:
  - cmd_oe=1; 48 bits, one per cycle: start 0, transmission 0, rsp_index, rsp_arg, crc7, end 1.
  - After the end bit: cmd_oe=0, cmd_out=1, state IDLE.
  - The next command start bit is accepted the cycle after returning to IDLE.
- Latency:
  - cmd_valid is asserted 1 cycle after the end bit is sampled.
  - The response start bit appears NCR_CYCLES+1 cycles after the rsp_valid handshake.
- Host traffic during TX/NCR is ignored; there is no collision detection.

Optional Feature:
CMD_CRC_CHECK_EN:
- Defined: CRC7 is checked in CHECK and crc_err is generated.
- Undefined: the received CRC field is ignored, crc_err is tied 0, and any well-framed command is accepted.
- Response CRC generation is present in both cases.

Test Plan:
- CMD0 frame 0x400000000095 -> cmd_valid pulse, cmd_index=0, cmd_arg=0; then rsp_none -> no cmd_oe assertion, busy falls.
- CMD8 frame 0x48000001AA87, respond index=8 arg=0x000001AA -> after NCR_CYCLES=2 idle cycles, cmd_out emits 0x08000001AA13 MSB first with cmd_oe high exactly 48 cycles.
- CMD17 frame 0x510000000055 with CRC field corrupted to 0x2B (with CMD_CRC_CHECK_EN) -> crc_err pulse, no cmd_valid, back to IDLE; without the macro -> cmd_valid with index 17.
- CMD55 frame 0x770000000065 with end bit forced 0 -> frame_err pulse, no cmd_valid.
- CMD8 accepted, rsp_valid never asserted, RSP_TIMEOUT=64 -> busy drops after 64 cycles, cmd_oe never 1.
- RST_L pulsed low mid-TX (bit 20) -> cmd_oe=0 and cmd_out=1 immediately; a following CMD0 is decoded normally.
